vocab_matcher: RTL and testbench
================================

VOCAB_MATCHER -- requirements
Module: vocab_matcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, width of vocab and input addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, character width; value 0 is the word terminator (null).
REQ-003 SHALL have parameter MAX_WORD_LEN, default 8, maximum input characters before a null is required.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  begin a search; sampled in IDLE or DONE.
- vocab_start_addr, vocab_end_addr, input_start_addr  in  ADDR_WIDTH each  region bounds; vocab region inclusive; sampled on start.
- addr_v, addr_i  out  ADDR_WIDTH each  vocab and input memory addresses.
- val_vocab, val_input  in  DATA_WIDTH each  read data, valid exactly 1 cycle after the address is presented.
- busy  out  1  search in progress.
- done  out  1  result valid.
- found  out  1  match found.
- err  out  1  input word longer than MAX_WORD_LEN.
- match_idx  out  ADDR_WIDTH  zero-based index of the matched vocab word.
- match_addr  out  ADDR_WIDTH  address of the first character of the matched word.

Function
REQ-005 SHALL implement states IDLE, RD, CMP, SKIP_RD, SKIP_CHK, DONE.
REQ-006 IDLE/DONE with start=1 SHALL:
- latch the bounds;
- set av=vocab_start_addr, ai=input_start_addr, word_base=av, word_idx=0, len=0;
- clear done/found/err;
- go to RD.
REQ-007 If vocab_end_addr < vocab_start_addr on start, SHALL go directly to DONE with found=0, err=0.
REQ-008 RD SHALL present av/ai and go to CMP next cycle (one wait cycle for read latency).
REQ-009 CMP SHALL evaluate in this priority order:
- (a) val_vocab==0 and val_input==0: DONE, found=1, match_idx=word_idx, match_addr=word_base.
- (b) val_input==0, val_vocab!=0, prefix mode active: same as (a).
- (c) equal non-null: if av==vocab_end_addr, DONE found=0; else if len+1==MAX_WORD_LEN, DONE err=1; else av+1, ai+1, len+1, go to RD.
- (d) val_vocab==0, val_input!=0: next-word step.
- (e) otherwise (mismatch, vocab non-null): go to SKIP_RD.
REQ-010 The next-word step SHALL:
- go to DONE with found=0 if av==vocab_end_addr;
- otherwise set av+1, word_base=av+1, word_idx+1, ai=input_start_addr, len=0, and go to RD.
REQ-011 SKIP_RD SHALL present av and go to SKIP_CHK. SKIP_CHK SHALL:
- on val_vocab==0, take the next-word step;
- else if av==vocab_end_addr, go to DONE found=0;
- else set av+1 and go to SKIP_RD.
REQ-012 Address arithmetic SHALL never wrap: no fetch is issued beyond vocab_end_addr.
REQ-013 busy SHALL be 1 in RD, CMP, SKIP_RD and SKIP_CHK, and 0 in IDLE and DONE.
REQ-014 done, found, err, match_idx and match_addr SHALL hold in DONE until the next accepted start; start while busy SHALL be ignored.
REQ-015 addr_v/addr_i SHALL be registered and equal av/ai; match_idx/match_addr SHALL be 0 whenever found=0.

Reset
REQ-016 rst_n=0 at a clock edge SHALL force IDLE and zero all outputs and internal counters, including mid-search; the search SHALL NOT resume after reset.

Configuration
REQ-017 With VOCAB_MATCHER_PREFIX_EN defined:
- the block SHALL add a 1-bit input prefix_mode, sampled on start, after the address outputs;
- rule REQ-009(b) SHALL apply when prefix_mode=1.
REQ-018 Without VOCAB_MATCHER_PREFIX_EN defined, the prefix_mode port SHALL be absent and only exact matching SHALL apply.

Structure
REQ-019 The state enum vocab_matcher_state_e and the terminator constant NULL_CHAR SHALL live in package vocab_matcher_pkg.
REQ-020 The block SHALL be a single module; no sub-module is required.

Verification
All scenarios use vocab at address 0 = {0x61,0x62,0,0x63,0x64,0}, vocab_end_addr=5, and input at address 0.
REQ-021 Input "cd\0" -> done=1, found=1, match_idx=1, match_addr=3, err=0.
REQ-022 Input "ce\0" -> done=1, found=0 after the vocab is exhausted at av=5.
REQ-023 Input "a\0":
- exact mode -> found=0;
- with VOCAB_MATCHER_PREFIX_EN and prefix_mode=1 -> found=1, match_idx=0, match_addr=0.
REQ-024 Input of 8 bytes of 0x61 against a vocab of 9 bytes of 0x61, MAX_WORD_LEN=8 -> done=1, err=1, found=0.
REQ-025 rst_n=0 for one cycle while busy=1 during the "cd" search -> IDLE, all outputs 0; start again -> same result as REQ-021.
REQ-026 vocab_start_addr=5 with vocab_end_addr=2 -> DONE within 1 cycle of start, found=0, err=0; start while busy -> ignored.

Source files
------------

// File: rtl/vocab_matcher_pkg.sv
// -----------------------------------------------------------------------------
// vocab_matcher_pkg
// Shared definitions for the vocabulary matcher: the FSM state encoding and
// the word terminator value.
// -----------------------------------------------------------------------------
package vocab_matcher_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        CMP      = 3'd2,
        SKIP_RD  = 3'd3,
        SKIP_CHK = 3'd4,
        DONE     = 3'd5
    } vocab_matcher_state_e;

    // Character value that terminates a word in both memories.
    localparam int unsigned NULL_CHAR = 0;

endpackage

// File: rtl/vocab_matcher.sv
// -----------------------------------------------------------------------------
// vocab_matcher
// Searches a null-separated vocabulary region for the null-terminated word held
// in an input region. Both regions live in external synchronous memories whose
// read data is valid one cycle after the address is presented.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start                   begin a search (accepted only in IDLE or DONE)
//   vocab_start_addr        first address of the vocab region
//   vocab_end_addr          last address of the vocab region (inclusive)
//   input_start_addr        first address of the input word
//   addr_v, addr_i          registered vocab / input memory addresses
//   prefix_mode             (VOCAB_MATCHER_PREFIX_EN only) input word may match
//                           as a prefix of a vocab word
//   val_vocab, val_input    memory read data
//   busy                    search in progress
//   done                    result valid, held until the next accepted start
//   found, match_idx,       match flag, zero-based word index and address of
//   match_addr              the first character of the matched word
//   err                     input word reached MAX_WORD_LEN without a null
//
// Build option: define VOCAB_MATCHER_PREFIX_EN to add the prefix_mode input.
// -----------------------------------------------------------------------------
module vocab_matcher
    import vocab_matcher_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_WORD_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
    input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
    input  logic [ADDR_WIDTH-1:0] input_start_addr,
    output logic [ADDR_WIDTH-1:0] addr_v,
    output logic [ADDR_WIDTH-1:0] addr_i,
`ifdef VOCAB_MATCHER_PREFIX_EN
    input  logic                  prefix_mode,
`endif
    input  logic [DATA_WIDTH-1:0] val_vocab,
    input  logic [DATA_WIDTH-1:0] val_input,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] match_idx,
    output logic [ADDR_WIDTH-1:0] match_addr
);

    localparam int LEN_W = $clog2(MAX_WORD_LEN + 1);
    localparam logic [LEN_W-1:0]      LAST_LEN = LEN_W'(MAX_WORD_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] NUL      = DATA_WIDTH'(NULL_CHAR);

    vocab_matcher_state_e  state_reg;
    logic [ADDR_WIDTH-1:0] av_reg;
    logic [ADDR_WIDTH-1:0] ai_reg;
    logic [ADDR_WIDTH-1:0] word_base_reg;
    logic [ADDR_WIDTH-1:0] word_idx_reg;
    logic [LEN_W-1:0]      len_reg;
    logic [ADDR_WIDTH-1:0] vocab_end_reg;
    logic [ADDR_WIDTH-1:0] input_start_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  found_reg;
    logic                  err_reg;
    logic [ADDR_WIDTH-1:0] match_idx_reg;
    logic [ADDR_WIDTH-1:0] match_addr_reg;
    logic                  prefix_active;

`ifdef VOCAB_MATCHER_PREFIX_EN
    logic prefix_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prefix_reg <= 1'b0;
        end else if (start && (state_reg == IDLE || state_reg == DONE)) begin
            prefix_reg <= prefix_mode;
        end
    end

    assign prefix_active = prefix_reg;
`else
    assign prefix_active = 1'b0;
`endif

    // Decode of what the comparison/skip states decide this cycle.
    logic at_end;
    logic step_hit;        // match: finish with found=1
    logic step_miss;       // vocab exhausted: finish with found=0
    logic step_overflow;   // input word too long: finish with err=1
    logic step_advance;    // characters equal: advance both pointers
    logic step_next_word;  // restart the input against the following word
    logic step_skip;       // mismatch: start scanning for the word's null
    logic step_skip_adv;   // still inside a skipped word: advance vocab only

    assign at_end = (av_reg == vocab_end_reg);

    always_comb begin
        step_hit       = 1'b0;
        step_miss      = 1'b0;
        step_overflow  = 1'b0;
        step_advance   = 1'b0;
        step_next_word = 1'b0;
        step_skip      = 1'b0;
        step_skip_adv  = 1'b0;
        case (state_reg)
            CMP: begin
                if ((val_vocab == NUL && val_input == NUL) ||
                    (val_input == NUL && prefix_active)) begin
                    step_hit = 1'b1;
                end else if (val_vocab == val_input) begin
                    // Both non-null here; the both-null case is caught above.
                    if (at_end)
                        step_miss = 1'b1;
                    else if (len_reg == LAST_LEN)
                        step_overflow = 1'b1;
                    else
                        step_advance = 1'b1;
                end else if (val_vocab == NUL) begin
                    if (at_end)
                        step_miss = 1'b1;
                    else
                        step_next_word = 1'b1;
                end else begin
                    step_skip = 1'b1;
                end
            end
            SKIP_CHK: begin
                if (val_vocab == NUL) begin
                    if (at_end)
                        step_miss = 1'b1;
                    else
                        step_next_word = 1'b1;
                end else if (at_end) begin
                    step_miss = 1'b1;
                end else begin
                    step_skip_adv = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            av_reg          <= '0;
            ai_reg          <= '0;
            word_base_reg   <= '0;
            word_idx_reg    <= '0;
            len_reg         <= '0;
            vocab_end_reg   <= '0;
            input_start_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            found_reg       <= 1'b0;
            err_reg         <= 1'b0;
            match_idx_reg   <= '0;
            match_addr_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        vocab_end_reg   <= vocab_end_addr;
                        input_start_reg <= input_start_addr;
                        av_reg          <= vocab_start_addr;
                        ai_reg          <= input_start_addr;
                        word_base_reg   <= vocab_start_addr;
                        word_idx_reg    <= '0;
                        len_reg         <= '0;
                        found_reg       <= 1'b0;
                        err_reg         <= 1'b0;
                        match_idx_reg   <= '0;
                        match_addr_reg  <= '0;
                        if (vocab_end_addr < vocab_start_addr) begin
                            // Empty vocab region: nothing to fetch.
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RD;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                end
                RD:      state_reg <= CMP;
                SKIP_RD: state_reg <= SKIP_CHK;
                CMP, SKIP_CHK: begin
                    if (step_hit) begin
                        state_reg      <= DONE;
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        found_reg      <= 1'b1;
                        match_idx_reg  <= word_idx_reg;
                        match_addr_reg <= word_base_reg;
                    end else if (step_miss) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (step_overflow) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                    end else if (step_advance) begin
                        av_reg    <= av_reg + 1'b1;
                        ai_reg    <= ai_reg + 1'b1;
                        len_reg   <= len_reg + 1'b1;
                        state_reg <= RD;
                    end else if (step_next_word) begin
                        av_reg        <= av_reg + 1'b1;
                        word_base_reg <= av_reg + 1'b1;
                        word_idx_reg  <= word_idx_reg + 1'b1;
                        ai_reg        <= input_start_reg;
                        len_reg       <= '0;
                        state_reg     <= RD;
                    end else if (step_skip) begin
                        // Re-present the same address; SKIP_CHK decides.
                        state_reg <= SKIP_RD;
                    end else if (step_skip_adv) begin
                        av_reg    <= av_reg + 1'b1;
                        state_reg <= SKIP_RD;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_v     = av_reg;
    assign addr_i     = ai_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign found      = found_reg;
    assign err        = err_reg;
    assign match_idx  = match_idx_reg;
    assign match_addr = match_addr_reg;

endmodule

// File: tb/tb_vocab_matcher.sv
// -----------------------------------------------------------------------------
// tb_vocab_matcher
// Directed and randomized checks of vocab_matcher against a word-level
// reference model. Two 16-entry memories with one cycle of read latency feed
// the DUT. Define VOCAB_MATCHER_PREFIX_EN to exercise the prefix_mode port.
// -----------------------------------------------------------------------------
module tb_vocab_matcher;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MAXLEN = 8;
`ifdef VOCAB_MATCHER_PREFIX_EN
    localparam bit HAS_PREFIX = 1'b1;
`else
    localparam bit HAS_PREFIX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] vocab_start_addr, vocab_end_addr, input_start_addr;
    logic [AW-1:0] addr_v, addr_i;
    logic          prefix_v;
    logic [DW-1:0] val_vocab, val_input;
    logic          busy, done, found, err;
    logic [AW-1:0] match_idx, match_addr;

    logic [DW-1:0] vmem [16];
    logic [DW-1:0] imem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        val_vocab <= vmem[addr_v];
        val_input <= imem[addr_i];
    end

    vocab_matcher #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_WORD_LEN(MAXLEN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vocab_start_addr(vocab_start_addr),
        .vocab_end_addr  (vocab_end_addr),
        .input_start_addr(input_start_addr),
        .addr_v          (addr_v),
        .addr_i          (addr_i),
`ifdef VOCAB_MATCHER_PREFIX_EN
        .prefix_mode     (prefix_v),
`endif
        .val_vocab       (val_vocab),
        .val_input       (val_input),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .err             (err),
        .match_idx       (match_idx),
        .match_addr      (match_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level model: walk the vocab word by word, comparing the input
    // string character by character against each word.
    task automatic model(input int vs, input int ve, input int is, input bit pre,
                         output bit f, output bit e, output int idx, output int addr);
        int  base, widx, k, q;
        bit  fin, word_done;
        logic [DW-1:0] v, c;
        f = 0; e = 0; idx = 0; addr = 0;
        if (ve < vs) return;
        base = vs; widx = 0; fin = 0;
        while (!fin) begin
            k = 0; word_done = 0;
            while (!word_done && !fin) begin
                v = vmem[base + k];
                c = imem[(is + k) % 16];
                if ((v == 0 && c == 0) || (c == 0 && pre)) begin
                    f = 1; idx = widx; addr = base; fin = 1;
                end else if (v == c) begin
                    if (base + k == ve) fin = 1;
                    else if (k + 1 == MAXLEN) begin e = 1; fin = 1; end
                    else k++;
                end else if (v == 0) begin
                    if (base + k == ve) fin = 1;
                    else begin base = base + k + 1; widx++; word_done = 1; end
                end else begin
                    // Input differs inside this word: find the word's end.
                    q = base + k;
                    while (vmem[q] != 0 && q != ve) q++;
                    if (q == ve) fin = 1;
                    else begin base = q + 1; widx++; word_done = 1; end
                end
            end
        end
    endtask

    // Called at a negedge; returns at a negedge after the start edge.
    task automatic kick(input int vs, input int ve, input int is, input bit pre);
        vocab_start_addr = AW'(vs);
        vocab_end_addr   = AW'(ve);
        input_start_addr = AW'(is);
        prefix_v         = pre;
        start            = 1'b1;
        @(negedge clk);
        start            = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 300 && !done; n++) @(negedge clk);
        chk({tag, ".done"}, done, 1);
    endtask

    task automatic run(input string tag, input int vs, input int ve, input int is, input bit pre);
        bit f, e;
        int idx, addr;
        model(vs, ve, is, pre && HAS_PREFIX, f, e, idx, addr);
        kick(vs, ve, is, pre);
        wait_done(tag);
        chk({tag, ".found"}, found, f);
        chk({tag, ".err"}, err, e);
        chk({tag, ".idx"}, match_idx, idx);
        chk({tag, ".addr"}, match_addr, addr);
        chk({tag, ".busy"}, busy, 0);
        $display("txn %s vs=%0d ve=%0d is=%0d pre=%0d -> found=%0d err=%0d idx=%0d addr=%0d",
                 tag, vs, ve, is, pre, found, err, match_idx, match_addr);
    endtask

    task automatic load_base_vocab();
        for (int i = 0; i < 16; i++) vmem[i] = 8'h7a;
        vmem[0] = 8'h61; vmem[1] = 8'h62; vmem[2] = 8'h00;
        vmem[3] = 8'h63; vmem[4] = 8'h64; vmem[5] = 8'h00;
    endtask

    task automatic load_input(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                              input logic [DW-1:0] c2);
        for (int i = 0; i < 16; i++) imem[i] = 8'h7a;
        imem[0] = c0; imem[1] = c1; imem[2] = c2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".addr_v"}, addr_v, 0);
        chk({tag, ".addr_i"}, addr_i, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".found"}, found, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".idx"}, match_idx, 0);
        chk({tag, ".addr"}, match_addr, 0);
    endtask

    initial begin
        int vs, ve, is, len;
        rst_n = 1'b0; start = 1'b0; prefix_v = 1'b0;
        vocab_start_addr = '0; vocab_end_addr = '0; input_start_addr = '0;
        for (int i = 0; i < 16; i++) begin vmem[i] = '0; imem[i] = '0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset");
        $display("txn reset outputs checked");

        // Exact match of the second word.
        load_base_vocab();
        load_input(8'h63, 8'h64, 8'h00);
        run("cd", 0, 5, 0, 0);
        chk("cd.exp_idx", match_idx, 1);
        chk("cd.exp_addr", match_addr, 3);

        // Vocab exhausted without match.
        load_input(8'h63, 8'h65, 8'h00);
        run("ce", 0, 5, 0, 0);
        chk("ce.exp_found", found, 0);

        // Prefix of the first word: exact vs prefix mode.
        load_input(8'h61, 8'h00, 8'h00);
        run("a_exact", 0, 5, 0, 0);
        chk("a_exact.exp_found", found, 0);
        run("a_prefix", 0, 5, 0, 1);
        chk("a_prefix.exp_found", found, HAS_PREFIX);

        // Overlong input word.
        for (int i = 0; i < 16; i++) begin
            vmem[i] = (i < 9) ? 8'h61 : 8'h00;
            imem[i] = (i < 8) ? 8'h61 : 8'h00;
        end
        run("long", 0, 8, 0, 0);
        chk("long.exp_err", err, 1);
        chk("long.exp_found", found, 0);

        // Reset in the middle of a search.
        load_base_vocab();
        load_input(8'h63, 8'h64, 8'h00);
        kick(0, 5, 0, 0);
        @(negedge clk);
        chk("midrst.busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midrst");
        repeat (6) @(negedge clk);
        chk("midrst.no_resume_busy", busy, 0);
        chk("midrst.no_resume_done", done, 0);
        $display("txn mid-search reset checked");
        run("cd_again", 0, 5, 0, 0);
        chk("cd_again.exp_idx", match_idx, 1);

        // Empty vocab range finishes within one cycle.
        kick(5, 2, 0, 0);
        chk("empty.done", done, 1);
        chk("empty.found", found, 0);
        chk("empty.err", err, 0);
        chk("empty.busy", busy, 0);
        $display("txn empty range done=%0d found=%0d", done, found);

        // Start while busy is ignored.
        kick(0, 5, 0, 0);
        @(negedge clk);
        chk("ignore.busy", busy, 1);
        kick(5, 2, 3, 0);
        chk("ignore.still_busy", busy, 1);
        wait_done("ignore");
        chk("ignore.found", found, 1);
        chk("ignore.idx", match_idx, 1);
        chk("ignore.addr", match_addr, 3);
        $display("txn start-while-busy found=%0d idx=%0d", found, match_idx);

        // Randomized vocab/input contents and bounds.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 3))
                    0:       vmem[i] = 8'h00;
                    1:       vmem[i] = 8'h61;
                    default: vmem[i] = 8'h62;
                endcase
                imem[i] = ($urandom_range(0, 1) == 0) ? 8'h61 : 8'h62;
            end
            ve  = $urandom_range(0, 15);
            vs  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, ve);
            is  = $urandom_range(0, 6);
            len = $urandom_range(0, 9);
            if (is + len < 16) imem[is + len] = 8'h00;
            run($sformatf("rnd%0d", t), vs, ve, is, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
